fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage between the program counter register and decode. Each cycle it reads the current PC, issues an in-order instruction-memory request, and drives the PC register's `pc_in`/`write_enable` with PC+4 or a redirect target. Returned instruction words are buffered with their PCs and handed to decode over a valid/ready handshake. A redirect flushes the buffer and discards responses to requests already in flight.

## Interface
- `WIDTH`, 32, PC and address width.
- `BUF_DEPTH`, 4, instruction buffer entries and maximum outstanding-plus-buffered requests (power of two, ≥2).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_cur`  in  WIDTH  current PC from program counter `pc_out`.
- `pc_next`  out  WIDTH  to program counter `pc_in`.
- `pc_we`  out  1  to program counter `write_enable`.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  WIDTH  word address, equals `pc_cur`.
- `imem_rsp_valid`  in  1  response valid; no backpressure, returns in request order.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  branch/exception redirect, single-cycle pulse.
- `redirect_pc`  in  WIDTH  redirect target.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts.
- `inst_data`  out  32  instruction word.
- `inst_pc`  out  WIDTH  PC of `inst_data`.

## Operation
- State: instruction buffer (BUF_DEPTH × {pc, data}, circular, rd/wr pointers plus count); in-flight PC FIFO (BUF_DEPTH entries); `outstanding` counter; `drop_cnt` counter; both counters $clog2(BUF_DEPTH+1) bits.
- Credit: `pop = inst_valid & inst_ready`. Issue allowed when `outstanding + occupancy − pop < BUF_DEPTH`.
- `imem_req_valid = credit & ~redirect_valid & ~reset`. Once asserted it holds with a stable address until `imem_req_ready`, except that it is withdrawn in a redirect cycle.
- Request handshake: push `pc_cur` into the in-flight FIFO, increment `outstanding`, `pc_we=1`, `pc_next = pc_cur + 4` (mod 2^WIDTH, wraps to 0).
- Response with `drop_cnt == 0`: pop the in-flight FIFO, write {pc, data} to the buffer, and decrement `outstanding`.
- Response with `drop_cnt > 0`: pop the in-flight FIFO, discard the data, and decrement both `drop_cnt` and `outstanding`.
- Redirect:
  - Drive `pc_we=1` and `pc_next = {redirect_pc[WIDTH-1:2], 2'b00}`. This takes priority over increment, and no request issues that cycle.
  - Clear buffer occupancy.
  - Set `drop_cnt = outstanding` (including any response arriving that same cycle, which is also dropped).
  - `inst_valid` is forced 0, so no pop occurs.
- Consecutive redirects: each recomputes `drop_cnt` from the current `outstanding`; the last target wins.
- `inst_valid = (occupancy != 0) & ~redirect_valid`. `inst_data`/`inst_pc` come from the buffer head and are held stable while `inst_valid & ~inst_ready`.
- Buffer overflow cannot occur by the credit rule. A response arriving with `outstanding == 0` is a protocol error; it is ignored and counters do not underflow.

## Timing
- Reset: `imem_req_valid=0`, `pc_we=0`, `inst_valid=0`; occupancy, pointers, `outstanding` and `drop_cnt` are 0 from the cycle after reset is sampled.
- Instruction memory shares `reset`; no pre-reset responses arrive after reset.
- `pc_next`/`pc_we` are combinational from the handshake, so the PC register updates at the end of the request cycle.
- Earliest response is the cycle after the request. The buffer write is registered: the response in cycle N gives `inst_valid` in cycle N+1.
- With 1-cycle memory and `inst_ready=1`, sustained throughput is one instruction per cycle. First instruction after reset release appears in cycle 2 (request in cycle 0).
- After a redirect in cycle R, the first request to the target issues in cycle R+1.

## Test plan
- Reset release with `pc_cur=0x0`, 1-cycle memory, `inst_ready=1`:
  - requests to 0x0, 0x4, 0x8 on consecutive cycles;
  - `inst_pc` 0x0, 0x4, 0x8 from cycle 2, one per cycle.
- Backpressure: `inst_ready=0`, BUF_DEPTH=4:
  - exactly 4 requests issue, then `imem_req_valid` stays 0;
  - raising `inst_ready` drains 4 entries in order while new requests resume.
- Redirect with 2 outstanding (3-cycle memory), `redirect_pc=0x103`:
  - `pc_next=0x100` with `pc_we=1`;
  - both stale responses are discarded;
  - next `inst_pc=0x100`.
- Redirect coincident with a response and with `inst_ready=1`:
  - response dropped, no pop;
  - `inst_valid=0` that cycle;
  - `drop_cnt` accounts correctly and no stale PC reaches decode.
- Wrap: `pc_cur=0xFFFFFFFC` request → `pc_next=0x00000000`.
- Mid-operation reset with 3 buffered entries → `inst_valid=0` and `outstanding=0` next cycle; the fetch restarts cleanly.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC register hookup, instruction-memory request/response,
// redirect input and the decode-side valid/ready channel.
interface fetch_stage_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] pc_cur;
   logic [WIDTH-1:0] pc_next;
   logic             pc_we;
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [WIDTH-1:0] imem_req_addr;
   logic             imem_rsp_valid;
   logic [31:0]      imem_rsp_data;
   logic             redirect_valid;
   logic [WIDTH-1:0] redirect_pc;
   logic             inst_valid;
   logic             inst_ready;
   logic [31:0]      inst_data;
   logic [WIDTH-1:0] inst_pc;

   modport master (
      input  pc_cur, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready,
      output pc_next, pc_we, imem_req_valid, imem_req_addr,
             inst_valid, inst_data, inst_pc
   );

   modport slave (
      output pc_cur, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready,
      input  pc_next, pc_we, imem_req_valid, imem_req_addr,
             inst_valid, inst_data, inst_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: issues in-order imem requests from the current PC, buffers
// returned words with their PCs for decode, and squashes in-flight work on redirect.
module fetch_stage #(
   parameter int WIDTH     = 32,
   parameter int BUF_DEPTH = 4
) (
   input logic           clk,
   input logic           reset,
   fetch_stage_if.master bus
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
   localparam logic [PW-1:0]    PTR_ONE    = PW'(1);
   localparam logic [CW:0]      DEPTH_W    = (CW + 1)'(BUF_DEPTH);
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));
   localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

   logic [WIDTH-1:0] buf_pc   [BUF_DEPTH];
   logic [31:0]      buf_data [BUF_DEPTH];
   logic [WIDTH-1:0] fly_pc   [BUF_DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    fly_rd;
   logic [PW-1:0]    fly_wr;
   logic [CW-1:0]    occupancy;
   logic [CW-1:0]    outstanding;
   logic [CW-1:0]    drop_cnt;

   logic             inst_valid;
   logic             pop;
   logic             credit;
   logic             req_valid;
   logic             req_fire;
   logic             rsp_ok;
   logic             rsp_keep;
   logic [CW:0]      used;
   logic [CW-1:0]    drop_load;

   // Credits count both in-flight requests and buffered words, so a response
   // always finds a free buffer slot.
   always_comb begin
      inst_valid = (occupancy != '0) & ~bus.redirect_valid & ~reset;
      pop        = inst_valid & bus.inst_ready;
      used       = {1'b0, outstanding} + {1'b0, occupancy} - {{CW{1'b0}}, pop};
      credit     = (used < DEPTH_W);
      req_valid  = credit & ~bus.redirect_valid & ~reset;
      req_fire   = req_valid & bus.imem_req_ready;
      rsp_ok     = bus.imem_rsp_valid & (outstanding != '0) & ~reset;
      rsp_keep   = rsp_ok & (drop_cnt == '0) & ~bus.redirect_valid;
      drop_load  = rsp_ok ? (outstanding - CNT_ONE) : outstanding;
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = bus.pc_cur;
   assign bus.pc_we          = ~reset & (bus.redirect_valid | req_fire);
   assign bus.pc_next        = bus.redirect_valid ? (bus.redirect_pc & ALIGN_MASK)
                                                  : (bus.pc_cur + PC_STEP);

   assign bus.inst_valid     = inst_valid;
   assign bus.inst_data      = buf_data[rd_ptr];
   assign bus.inst_pc        = buf_pc[rd_ptr];

   // Control state: pointers and counters.  A redirect leaves exactly the
   // requests still in flight after this cycle marked for discard.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         occupancy   <= '0;
         fly_rd      <= '0;
         fly_wr      <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (req_fire) fly_wr <= fly_wr + PTR_ONE;
         if (rsp_ok)   fly_rd <= fly_rd + PTR_ONE;

         case ({req_fire, rsp_ok})
            2'b10:   outstanding <= outstanding + CNT_ONE;
            2'b01:   outstanding <= outstanding - CNT_ONE;
            default: outstanding <= outstanding;
         endcase

         if (bus.redirect_valid) begin
            drop_cnt  <= drop_load;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
         end else begin
            if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_ONE;
            if (rsp_keep) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
            case ({rsp_keep, pop})
               2'b10:   occupancy <= occupancy + CNT_ONE;
               2'b01:   occupancy <= occupancy - CNT_ONE;
               default: occupancy <= occupancy;
            endcase
         end
      end
   end

   // Data storage carries no reset; validity is tracked by the control state.
   always_ff @(posedge clk) begin
      if (req_fire) fly_pc[fly_wr] <= bus.pc_cur;
      if (rsp_keep) begin
         buf_pc[wr_ptr]   <= fly_pc[fly_rd];
         buf_data[wr_ptr] <= bus.imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC register and in-order memory models, a queue-based
// reference checked every cycle, directed scenarios and a randomized phase.
module tb_fetch_stage;
   localparam int DEPTH = 4;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } fly_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_stage_if #(.WIDTH(32)) ifc ();
   fetch_stage #(.WIDTH(32), .BUF_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(ifc));

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          mem_lat = 1;
   int          lat_extra = 0;
   bit          rdy_rand = 1'b0;
   bit          pc_load = 1'b0;
   logic [31:0] pc_load_val = 32'h0;

   mreq_t       mq[$];
   fly_t        fq[$];
   logic [31:0] bq[$];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // PC register and fixed/random-latency in-order instruction memory.
   logic [31:0] env_nxt;
   int          env_due;
   int          env_last_due = 0;
   mreq_t       env_m;
   initial begin : env
      ifc.pc_cur         = 32'h0;
      ifc.imem_req_ready = 1'b1;
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = 32'h0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mq.delete();
            env_last_due = cyc;
         end else if (ifc.imem_req_valid && ifc.imem_req_ready) begin
            env_due = cyc + mem_lat + ((lat_extra > 0) ? int'($urandom_range(0, lat_extra)) : 0);
            if (env_due <= env_last_due) env_due = env_last_due + 1;
            env_last_due = env_due;
            env_m.due  = env_due;
            env_m.addr = ifc.imem_req_addr;
            mq.push_back(env_m);
         end
         env_nxt = pc_load ? pc_load_val : (ifc.pc_we ? ifc.pc_next : ifc.pc_cur);
         @(posedge clk);
         #1;
         cyc++;
         ifc.pc_cur = env_nxt;
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            ifc.imem_rsp_valid = 1'b1;
            ifc.imem_rsp_data  = word_of(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            ifc.imem_rsp_valid = 1'b0;
            ifc.imem_rsp_data  = $urandom;
         end
         ifc.imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Reference: in-flight requests carry a stale flag set by a redirect;
   // the buffer is a queue of PCs whose data follows from memory contents.
   bit          sb_on = 1'b0;
   bit          sb_rst, sb_redir, sb_iv, sb_pop, sb_rv, sb_fire, sb_we;
   int          sb_used;
   fly_t        sb_f;
   initial begin : scoreboard
      forever begin
         @(negedge clk);
         if (reset) sb_on = 1'b1;
         if (sb_on) begin
            sb_rst   = reset;
            sb_redir = ifc.redirect_valid;
            sb_iv    = !sb_rst && (bq.size() > 0) && !sb_redir;
            check_b("m_inst_valid", ifc.inst_valid, sb_iv);
            if (sb_iv) begin
               check("m_inst_pc", ifc.inst_pc, bq[0]);
               check("m_inst_data", ifc.inst_data, word_of(bq[0]));
            end
            sb_pop  = sb_iv && ifc.inst_ready;
            sb_used = fq.size() + bq.size() - (sb_pop ? 1 : 0);
            sb_rv   = !sb_rst && !sb_redir && (sb_used < DEPTH);
            check_b("m_req_valid", ifc.imem_req_valid, sb_rv);
            if (sb_rv) check("m_req_addr", ifc.imem_req_addr, ifc.pc_cur);
            sb_fire = sb_rv && ifc.imem_req_ready;
            sb_we   = !sb_rst && (sb_redir || sb_fire);
            check_b("m_pc_we", ifc.pc_we, sb_we);
            if (sb_we)
               check("m_pc_next", ifc.pc_next,
                     sb_redir ? {ifc.redirect_pc[31:2], 2'b00} : ifc.pc_cur + 32'd4);

            if (sb_rst) begin
               fq.delete();
               bq.delete();
            end else begin
               if (sb_pop) void'(bq.pop_front());
               if (ifc.imem_rsp_valid && fq.size() > 0) begin
                  sb_f = fq.pop_front();
                  if (!sb_f.stale && !sb_redir) bq.push_back(sb_f.pc);
               end
               if (sb_fire) begin
                  sb_f.pc    = ifc.pc_cur;
                  sb_f.stale = 1'b0;
                  fq.push_back(sb_f);
               end
               if (sb_redir) begin
                  for (int i = 0; i < fq.size(); i++) fq[i].stale = 1'b1;
                  bq.delete();
               end
            end
         end
      end
   end

   task automatic do_reset(input logic [31:0] pc);
      reset       = 1'b1;
      pc_load     = 1'b1;
      pc_load_val = pc;
      tick();
      @(negedge clk);
      check_b("rst_req_valid", ifc.imem_req_valid, 1'b0);
      check_b("rst_pc_we", ifc.pc_we, 1'b0);
      check_b("rst_inst_valid", ifc.inst_valid, 1'b0);
      tick();
      reset   = 1'b0;
      pc_load = 1'b0;
   endtask

   task automatic expect_first_inst(input string name, input logic [31:0] exp_pc);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (ifc.inst_valid) begin
            found = 1'b1;
            check(name, ifc.inst_pc, exp_pc);
         end
         tick();
      end
      check_b({name, "_seen"}, found, 1'b1);
   endtask

   int n_req;
   int got;
   bit resumed;

   initial begin : main
      reset              = 1'b1;
      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc    = 32'h0;
      ifc.inst_ready     = 1'b1;

      // Reset release, 1-cycle memory, streaming decode.
      mem_lat = 1;
      do_reset(32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 3) begin
            check_b("seq_req_valid", ifc.imem_req_valid, 1'b1);
            check("seq_req_addr", ifc.imem_req_addr, 32'(4 * k));
         end
         if (k >= 2) begin
            check_b("seq_inst_valid", ifc.inst_valid, 1'b1);
            check("seq_inst_pc", ifc.inst_pc, 32'(4 * (k - 2)));
         end
         tick();
      end

      // Backpressure: credits run out after DEPTH requests.
      ifc.inst_ready = 1'b0;
      do_reset(32'h200);
      n_req = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ifc.imem_req_valid && ifc.imem_req_ready) n_req++;
         tick();
      end
      check("bp_req_count", 32'(n_req), 32'd4);
      @(negedge clk);
      check_b("bp_req_stalled", ifc.imem_req_valid, 1'b0);
      tick();
      ifc.inst_ready = 1'b1;
      got = 0;
      resumed = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (ifc.inst_valid && ifc.inst_ready) begin
            if (got < 4) check("bp_drain_pc", ifc.inst_pc, 32'h200 + 32'(4 * got));
            got++;
         end
         if (ifc.imem_req_valid && ifc.imem_req_ready) resumed = 1'b1;
         tick();
      end
      check_b("bp_drain_count", got >= 4, 1'b1);
      check_b("bp_resumed", resumed, 1'b1);

      // Redirect with two requests outstanding on a 3-cycle memory.
      mem_lat = 3;
      do_reset(32'h40);
      tick();
      tick();
      ifc.redirect_valid = 1'b1;
      ifc.redirect_pc    = 32'h103;
      @(negedge clk);
      check_b("redir_pc_we", ifc.pc_we, 1'b1);
      check("redir_pc_next", ifc.pc_next, 32'h100);
      check_b("redir_no_req", ifc.imem_req_valid, 1'b0);
      tick();
      ifc.redirect_valid = 1'b0;
      expect_first_inst("redir_first_pc", 32'h100);

      // Redirect coincident with a response while decode is ready.
      mem_lat = 2;
      do_reset(32'h800);
      repeat (5) tick();
      ifc.redirect_valid = 1'b1;
      ifc.redirect_pc    = 32'h1002;
      @(negedge clk);
      check_b("coinc_inst_valid", ifc.inst_valid, 1'b0);
      check("coinc_pc_next", ifc.pc_next, 32'h1000);
      tick();
      ifc.redirect_valid = 1'b0;
      expect_first_inst("coinc_first_pc", 32'h1000);

      // PC increment wraps at the top of the address space.
      mem_lat = 1;
      do_reset(32'hFFFF_FFFC);
      @(negedge clk);
      check("wrap_req_addr", ifc.imem_req_addr, 32'hFFFF_FFFC);
      check_b("wrap_pc_we", ifc.pc_we, 1'b1);
      check("wrap_pc_next", ifc.pc_next, 32'h0);
      tick();
      @(negedge clk);
      check("wrap_req_addr2", ifc.imem_req_addr, 32'h0);
      tick();

      // Reset in the middle of operation with three buffered entries.
      ifc.inst_ready = 1'b0;
      do_reset(32'h300);
      repeat (4) tick();
      @(negedge clk);
      check_b("mid_buffered_valid", ifc.inst_valid, 1'b1);
      check("mid_buffered_pc", ifc.inst_pc, 32'h300);
      tick();
      do_reset(32'h500);
      @(negedge clk);
      check_b("mid_after_inst_valid", ifc.inst_valid, 1'b0);
      check_b("mid_after_req_valid", ifc.imem_req_valid, 1'b1);
      check("mid_after_req_addr", ifc.imem_req_addr, 32'h500);
      tick();
      ifc.inst_ready = 1'b1;
      expect_first_inst("mid_restart_pc", 32'h500);

      // Randomized traffic: latency, memory stalls, decode stalls, redirects, resets.
      lat_extra = 3;
      rdy_rand  = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         ifc.inst_ready     = ($urandom_range(0, 3) != 0);
         ifc.redirect_valid = ($urandom_range(0, 19) == 0);
         ifc.redirect_pc    = $urandom;
         reset              = ($urandom_range(0, 399) == 0);
         tick();
      end
      reset              = 1'b0;
      ifc.redirect_valid = 1'b0;
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
      $fatal(1, "timeout");
   end
endmodule
